bram_byte_controller: RTL

Parametrised BRAM slave for the CPU's valid/ready memory bus, succeeding the fixed 8 KB word-only controller. It adds configurable depth, base address and response latency, per-byte write strobes, optional hex preload, and an error response for out-of-window addresses. It sits between the core's memory port and a single inferred block RAM, in parallel with the UART and LED peripherals on the address decoder.

---
 rtl/bram_byte_controller.sv | 115 +++++++++++
 1 files changed

// File: rtl/bram_byte_controller.sv
// rtl/bram_byte_controller.sv - valid/ready BRAM slave with byte strobes, window check and fixed latency
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_valid/mem_ready   request / one-cycle response strobe
//   mem_addr              byte address (bits [1:0] ignored)
//   mem_wdata/mem_wstrb   write data and byte enables (4'b0000 = read)
//   mem_rdata/mem_err     read data and out-of-window flag, valid with mem_ready
module bram_byte_controller #(
   parameter int          DEPTH     = 2048,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LATENCY   = 3,
   parameter string       INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_err
);

   localparam int          AW   = $clog2(DEPTH);
   localparam logic [31:0] BASE = BASE_ADDR;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        oow_q;
   logic [31:0] mem [DEPTH];

   logic          in_win;
   logic [AW-1:0] idx;
   logic          accept;
   logic          unused_addr;

   // BASE is aligned to the window size, so the window test reduces to
   // comparing the bits above the index field; no wrap into word 0 is possible.
   assign in_win      = (mem_addr[31:AW+2] == BASE[31:AW+2]);
   assign idx         = mem_addr[AW+1:2];
   assign accept      = (state == IDLE) && mem_valid && !reset;
   assign unused_addr = ^mem_addr[1:0];

   // Decoded from the state register only: no path from bus inputs.
   assign mem_ready = (state == RESP);

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'h0;
      end
   end

   // RAM array: no reset, so contents survive reset; lanes without a strobe keep their data.
   always_ff @(posedge clk) begin
      if (accept && in_win) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_wstrb[i]) begin
               mem[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         oow_q     <= 1'b0;
         mem_rdata <= 32'h0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem_err <= 1'b0;
               if (mem_valid) begin
                  // Read-first: the NBA samples the pre-write word.
                  mem_rdata <= in_win ? mem[idx] : 32'h0;
                  oow_q     <= !in_win;
                  if (LATENCY == 1) begin
                     state   <= RESP;
                     mem_err <= !in_win;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state   <= RESP;
                  mem_err <= oow_q;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state   <= IDLE;
               mem_err <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               mem_err <= 1'b0;
            end
         endcase
      end
   end

endmodule
